// File: rtl/bsg_then_ready_link_rr_scheduler.sv
// Round-robin scheduler serializing wide ready_and requesters onto a narrow
// then_ready link as one header flit (grant id) followed by payload flits.
module bsg_then_ready_link_rr_scheduler #(
   parameter int num_in_p          = 4,
   parameter int wide_link_width_p = 32,
   parameter int bsg_link_width_p  = 8
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic [num_in_p-1:0]                   wide_v_i,
   input  logic [num_in_p*wide_link_width_p-1:0] wide_data_i,
   output logic [num_in_p-1:0]                   wide_ready_and_o,
   output logic                                  link_v_o,
   output logic [bsg_link_width_p-1:0]           link_data_o,
   input  logic                                  link_then_ready_i,
   output logic [$clog2(num_in_p)-1:0]           grant_id_o
);

   localparam int ratio_lp = (wide_link_width_p + bsg_link_width_p - 1)
                             / bsg_link_width_p;
   localparam int id_w_lp  = $clog2(num_in_p);
   localparam int cnt_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
   localparam int pad_w_lp = ratio_lp * bsg_link_width_p;

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

   state_e                state_q, state_d;
   logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
   logic [id_w_lp-1:0]    ptr_q, ptr_d;
   logic [id_w_lp-1:0]    id_q, id_d;
   logic [pad_w_lp-1:0]   data_q, data_d;
   logic                  armed_q;

   logic                  arb, grant, last;
   logic [id_w_lp-1:0]    win;

   // Scan farthest-first so the nearest valid at or after ptr wins.
   function automatic logic [id_w_lp-1:0] rr_pick(
      input logic [id_w_lp-1:0]  ptr,
      input logic [num_in_p-1:0] v
   );
      logic [id_w_lp-1:0] jj;
      rr_pick = '0;
      for (int k = num_in_p - 1; k >= 0; k--) begin
         jj = id_w_lp'((int'(ptr) + k) % num_in_p);
         if (v[jj]) rr_pick = jj;
      end
   endfunction

   assign win  = rr_pick(ptr_q, wide_v_i);
   assign last = (cnt_q == cnt_w_lp'(ratio_lp - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      data_d  = data_q;
      arb     = 1'b0;
      unique case (state_q)
         IDLE: arb = 1'b1;
         HDR: begin
            if (link_then_ready_i) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (link_then_ready_i) begin
               if (last) begin
                  arb     = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + cnt_w_lp'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // No arbitration while in reset or on the first cycle out of it.
      grant = arb & armed_q & reset_n_i & (|wide_v_i);
      if (grant) begin
         state_d = HDR;
         id_d    = win;
         ptr_d   = (win == id_w_lp'(num_in_p - 1)) ? '0 : win + id_w_lp'(1);
         data_d  = '0;
         data_d[wide_link_width_p-1:0] =
            wide_data_i[win*wide_link_width_p +: wide_link_width_p];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         data_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      wide_ready_and_o = grant ? (num_in_p'(1) << win) : '0;
      link_v_o         = reset_n_i & (state_q != IDLE);
      link_data_o      = '0;
      if (reset_n_i && state_q == HDR)
         link_data_o = bsg_link_width_p'(id_q);
      else if (reset_n_i && state_q == DATA)
         link_data_o = data_q[cnt_q*bsg_link_width_p +: bsg_link_width_p];
   end

   assign grant_id_o = id_q;

endmodule

// File: tb/tb_bsg_then_ready_link_rr_scheduler.sv
// Randomized + directed bench; reference model is a per-packet flit queue.
module tb_bsg_then_ready_link_rr_scheduler;

   localparam int N  = 4;
   localparam int WW = 32;
   localparam int LW = 8;
   localparam int R  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic [N-1:0]    v = '0;
   logic [N*WW-1:0] d = '0;
   logic            tr = 1'b0;
   logic [N-1:0]    rdy;
   logic            lv;
   logic [LW-1:0]   ld;
   logic [1:0]      gid;

   logic [3:0]      v2 = '0;
   logic [79:0]     d2 = '0;
   logic            tr2 = 1'b0;
   logic [3:0]      rdy2;
   logic            lv2;
   logic [7:0]      ld2;
   logic [1:0]      gid2;

   bsg_then_ready_link_rr_scheduler #(
      .num_in_p(N), .wide_link_width_p(WW), .bsg_link_width_p(LW)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n), .wide_v_i(v), .wide_data_i(d),
      .wide_ready_and_o(rdy), .link_v_o(lv), .link_data_o(ld),
      .link_then_ready_i(tr), .grant_id_o(gid)
   );

   bsg_then_ready_link_rr_scheduler #(
      .num_in_p(4), .wide_link_width_p(20), .bsg_link_width_p(8)
   ) dut2 (
      .clk_i(clk), .reset_n_i(rst_n), .wide_v_i(v2), .wide_data_i(d2),
      .wide_ready_and_o(rdy2), .link_v_o(lv2), .link_data_o(ld2),
      .link_then_ready_i(tr2), .grant_id_o(gid2)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: flits still to be sent, rr pointer, last grant.
   logic [7:0] mq[$];
   int  mptr  = 0;
   int  mgid  = 0;
   bit  marmed = 0;

   logic [LW-1:0] obs_data;
   logic          obs_v;
   logic [N-1:0]  obs_rdy;

   task automatic step(input logic [N-1:0] vi, input logic [N*WW-1:0] di,
                       input logic ti, input logic ri);
      int win;
      bit ev, slot;
      logic [LW-1:0] el;
      logic [N-1:0]  er;
      @(negedge clk);
      v = vi; d = di; tr = ti; rst_n = ri;
      #1;
      ev   = ri && (mq.size() > 0);
      el   = ev ? mq[0] : '0;
      slot = ri && marmed && (mq.size() == 0 || (mq.size() == 1 && ti));
      win  = -1;
      if (slot)
         for (int k = 0; k < N; k++)
            if (win < 0 && vi[(mptr + k) % N]) win = (mptr + k) % N;
      er = (win >= 0) ? (N'(1) << win) : '0;
      chk("link_v", 64'(lv), 64'(ev));
      chk("link_data", 64'(ld), 64'(el));
      chk("ready_and", 64'(rdy), 64'(er));
      chk("grant_id", 64'(gid), 64'(mgid));
      obs_data = ld; obs_v = lv; obs_rdy = rdy;
      @(posedge clk);
      if (!ri) begin
         mq.delete(); mptr = 0; mgid = 0; marmed = 0;
      end else begin
         marmed = 1;
         if (ev && ti) void'(mq.pop_front());
         if (win >= 0) begin
            mq.push_back(8'(win));
            for (int b = 0; b < R; b++) mq.push_back(di[win*WW + b*LW +: LW]);
            mgid = win;
            mptr = (win + 1) % N;
         end
      end
   endtask

   logic [7:0] e32 [5] = '{8'h02, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
   logic [7:0] e35 [4] = '{8'h01, 8'hDE, 8'hBC, 8'h0A};
   logic [N*WW-1:0] p2;
   int gq[$];

   initial begin
      p2 = '0;
      p2[2*WW +: WW] = 32'hA1B2C3D4;

      step('0, '0, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      chk("rst_link_v", 64'(obs_v), 64'd0);
      // idle with then_ready high: nothing happens
      step('0, '0, 1'b1, 1'b1);
      step('0, '0, 1'b1, 1'b1);
      step('0, '0, 1'b1, 1'b1);
      chk("idle_tr_v", 64'(obs_v), 64'd0);

      // single requester packet
      step(4'b0100, p2, 1'b1, 1'b1);
      chk("req2_ready", 64'(obs_rdy), 64'h4);
      for (int i = 0; i < 5; i++) begin
         step('0, p2, 1'b1, 1'b1);
         chk($sformatf("req2_flit%0d", i), 64'(obs_data), 64'(e32[i]));
      end
      step('0, p2, 1'b1, 1'b1);
      chk("req2_done_v", 64'(obs_v), 64'd0);

      // backpressure on 0xC3
      step(4'b0100, p2, 1'b1, 1'b1);
      step('0, p2, 1'b1, 1'b1);
      step('0, p2, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step('0, p2, 1'b0, 1'b1);
         chk("stall_C3", 64'(obs_data), 64'hC3);
      end
      for (int i = 2; i < 5; i++) begin
         step('0, p2, 1'b1, 1'b1);
         chk($sformatf("resume%0d", i), 64'(obs_data), 64'(e32[i]));
      end

      // all requesters, back-to-back round robin from fresh reset
      step('0, '0, 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 21; i++) begin
         step(4'hF, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
         for (int k = 0; k < N; k++) if (obs_rdy[k]) gq.push_back(k);
      end
      chk("rr_count", 64'(gq.size()), 64'd5);
      for (int i = 0; i < 5 && i < gq.size(); i++)
         chk($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(i % N));

      // reset mid-packet, then req0 beats req3
      step(4'hF, '1, 1'b1, 1'b1);
      step(4'hF, '1, 1'b1, 1'b1);
      step(4'hF, '1, 1'b1, 1'b1);
      step(4'b1001, '1, 1'b1, 1'b0);
      step(4'b1001, '1, 1'b1, 1'b1);
      chk("post_rst_v", 64'(obs_v), 64'd0);
      chk("post_rst_rdy", 64'(obs_rdy), 64'd0);
      step(4'b1001, '1, 1'b1, 1'b1);
      chk("post_rst_req0", 64'(obs_rdy), 64'h1);

      for (int i = 0; i < 2000; i++)
         step(N'($urandom), {$urandom, $urandom, $urandom, $urandom},
              1'(($urandom % 10) < 7), 1'(($urandom % 50) != 0));
      step('0, '0, 1'b1, 1'b1);
      step('0, '0, 1'b1, 1'b1);

      // ratio-3 instance: 20-bit payload from req1
      @(negedge clk);
      v2 = 4'b0010; d2 = 80'h0;
      d2[20 +: 20] = 20'hABCDE; tr2 = 1'b1;
      #1;
      chk("r3_ready", 64'(rdy2), 64'h2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         v2 = '0;
         #1;
         chk($sformatf("r3_v%0d", i), 64'(lv2), 64'd1);
         chk($sformatf("r3_flit%0d", i), 64'(ld2), 64'(e35[i]));
      end
      @(negedge clk);
      #1;
      chk("r3_done_v", 64'(lv2), 64'd0);
      chk("r3_gid", 64'(gid2), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
